// File: rtl/dma_wr_ctrl.sv
// dma_wr_ctrl: buffers a beat stream and issues fixed-size write bursts into a ring buffer.
// A command strobe precedes each burst by one cycle; data follows on consecutive cycles.
module dma_wr_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 16,
    parameter int FIFO_DEPTH = 512
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          cfg_en,
    input  logic [ADDR_WIDTH-1:0]         cfg_base_addr,
    input  logic [ADDR_WIDTH-1:0]         cfg_ring_size,
    input  logic [LEN_WIDTH-1:0]          cfg_burst_len,
    input  logic                          s_vld,
    input  logic [DATA_WIDTH-1:0]         s_data,
    output logic                          s_rdy,
    input  logic                          wready,
    output logic                          wstart,
    output logic [ADDR_WIDTH-1:0]         waddr,
    output logic [LEN_WIDTH-1:0]          wdata_len,
    output logic                          wdata_vld,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic                          busy,
    output logic                          burst_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic                  cfg_en_q;
    logic [ADDR_WIDTH-1:0] base_q, ring_q, offset, next_off;
    logic [LEN_WIDTH-1:0]  len_q, beats, rem;
    logic                  push, pop;

    // Full exactly when the count's top bit is set, since the depth is a power of two.
    assign s_rdy    = !fifo_cnt[AW];
    assign push     = s_vld && s_rdy;
    assign pop      = (state == CMD) || (state == DATA && rem != '0);
    assign beats    = len_q >> 3;
    assign next_off = offset + ADDR_WIDTH'(len_q);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= s_data;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
        end
    end

    // Starting a burst waits for cfg_en_q so the latched configuration is already valid.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            cfg_en_q   <= 1'b0;
            base_q     <= '0;
            ring_q     <= '0;
            len_q      <= '0;
            offset     <= '0;
            rem        <= '0;
            wstart     <= 1'b0;
            waddr      <= '0;
            wdata_len  <= '0;
            wdata_vld  <= 1'b0;
            wdata      <= '0;
            busy       <= 1'b0;
            burst_done <= 1'b0;
        end else begin
            cfg_en_q   <= cfg_en;
            wstart     <= 1'b0;
            burst_done <= 1'b0;
            if (cfg_en && !cfg_en_q) begin
                base_q <= cfg_base_addr;
                ring_q <= cfg_ring_size;
                len_q  <= cfg_burst_len;
                offset <= '0;
            end
            case (state)
                IDLE: if (cfg_en && cfg_en_q && wready && 32'(fifo_cnt) >= 32'(beats)) begin
                    state     <= CMD;
                    wstart    <= 1'b1;
                    busy      <= 1'b1;
                    waddr     <= base_q + offset;
                    wdata_len <= len_q;
                end
                CMD: begin
                    state      <= DATA;
                    wdata_vld  <= 1'b1;
                    wdata      <= mem[rd_ptr];
                    rem        <= beats - 1'b1;
                    burst_done <= beats == LEN_WIDTH'(1);
                end
                DATA: if (rem == '0) begin
                    state     <= IDLE;
                    wdata_vld <= 1'b0;
                    busy      <= 1'b0;
                    offset    <= (next_off == ring_q) ? '0 : next_off;
                end else begin
                    wdata      <= mem[rd_ptr];
                    rem        <= rem - 1'b1;
                    burst_done <= rem == LEN_WIDTH'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dma_wr_ctrl.sv
// tb_dma_wr_ctrl: directed scenarios for dma_wr_ctrl with hand-computed expectations.
module tb_dma_wr_ctrl;
    logic        clk = 0, rstn = 0, cfg_en = 0, s_vld = 0, wready = 0;
    logic [31:0] cfg_base_addr = 32'h1000_0000, cfg_ring_size = 32'h400;
    logic [15:0] cfg_burst_len = 16'h100;
    logic [63:0] s_data = '0;
    logic        s_rdy, wstart, wdata_vld, busy, burst_done;
    logic [31:0] waddr;
    logic [15:0] wdata_len;
    logic [63:0] wdata;
    logic [9:0]  fifo_cnt;

    int checks = 0, failures = 0, cyc = 0, run = 0;
    logic vld_prev = 0;
    logic [63:0] pv = 64'h1111_0000_0000_0000;
    logic [63:0] exp_q[$], got[$];
    logic [31:0] wst_addr[$];
    logic [15:0] wst_len[$];
    int wst_cyc[$], first_cyc[$], last_cyc[$], runs[$], done_idx[$];

    dma_wr_ctrl dut (
        .clk(clk), .rstn(rstn), .cfg_en(cfg_en), .cfg_base_addr(cfg_base_addr),
        .cfg_ring_size(cfg_ring_size), .cfg_burst_len(cfg_burst_len), .s_vld(s_vld),
        .s_data(s_data), .s_rdy(s_rdy), .wready(wready), .wstart(wstart), .waddr(waddr),
        .wdata_len(wdata_len), .wdata_vld(wdata_vld), .wdata(wdata), .busy(busy),
        .burst_done(burst_done), .fifo_cnt(fifo_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Recorder only: captures commands, beats and burst boundaries for the tasks to judge.
    always @(negedge clk) begin
        if (wstart) begin
            wst_addr.push_back(waddr);
            wst_len.push_back(wdata_len);
            wst_cyc.push_back(cyc);
        end
        if (wdata_vld) begin
            if (!vld_prev) first_cyc.push_back(cyc);
            got.push_back(wdata);
            run++;
        end else if (vld_prev) begin
            runs.push_back(run);
            last_cyc.push_back(cyc - 1);
            run = 0;
        end
        if (burst_done) done_idx.push_back(wdata_vld ? got.size() : -1);
        vld_prev = wdata_vld;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    function automatic int first_bad();
        for (int i = 0; i < got.size(); i++)
            if (i >= exp_q.size() || got[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic clear_mon();
        wst_addr.delete(); wst_len.delete(); wst_cyc.delete();
        first_cyc.delete(); last_cyc.delete(); runs.delete(); done_idx.delete();
    endtask

    task automatic enable_cfg();
        cfg_en = 0;
        repeat (2) @(posedge clk);
        #1 cfg_base_addr = 32'h1000_0000; cfg_ring_size = 32'h400; cfg_burst_len = 16'h100;
        cfg_en = 1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic push_n(input int n, input int max_cyc, output int acc);
        logic a;
        acc = 0;
        @(posedge clk); #1;
        for (int c = 0; c < max_cyc && acc < n; c++) begin
            s_vld = 1; s_data = pv;
            @(negedge clk); a = s_rdy;
            @(posedge clk); #1;
            if (a) begin exp_q.push_back(pv); pv++; acc++; end
        end
        s_vld = 0;
    endtask

    task automatic wait_beats(input int n, input int budget, output bit ok);
        ok = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (got.size() >= n && !busy) begin ok = 1; break; end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 0;
        repeat (3) @(posedge clk);
        #1 rstn = 1;
        @(negedge clk);
        checks += 9;
        if (fifo_cnt !== 0)   begin failures++; $display("FAIL rst_fifo_cnt got=%0d exp=0", fifo_cnt); end
        if (s_rdy !== 1)      begin failures++; $display("FAIL rst_s_rdy got=%b exp=1", s_rdy); end
        if (busy !== 0)       begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        if (wstart !== 0)     begin failures++; $display("FAIL rst_wstart got=%b exp=0", wstart); end
        if (wdata_vld !== 0)  begin failures++; $display("FAIL rst_wdata_vld got=%b exp=0", wdata_vld); end
        if (burst_done !== 0) begin failures++; $display("FAIL rst_burst_done got=%b exp=0", burst_done); end
        if (waddr !== 0)      begin failures++; $display("FAIL rst_waddr got=%0h exp=0", waddr); end
        if (wdata_len !== 0)  begin failures++; $display("FAIL rst_wdata_len got=%0h exp=0", wdata_len); end
        if (wdata !== 0)      begin failures++; $display("FAIL rst_wdata got=%0h exp=0", wdata); end
    endtask

    task automatic test_single_burst();
        int acc, b;
        bit ok;
        clear_mon();
        enable_cfg();
        wready = 1;
        push_n(32, 100, acc);
        cfg_base_addr = 32'hDEAD_0000; cfg_burst_len = 16'h40;
        wait_beats(32, 200, ok);
        cfg_base_addr = 32'h1000_0000; cfg_burst_len = 16'h100;
        b = first_bad();
        checks += 8;
        if (!ok) begin failures++; $display("FAIL single_timeout got=%0d beats exp=32", got.size()); end
        if (wst_addr.size() !== 1 || wst_addr[0] !== 32'h1000_0000)
            begin failures++; $display("FAIL single_waddr n=%0d got=%0h exp=10000000", wst_addr.size(), wst_addr[0]); end
        if (wst_len[0] !== 16'h100) begin failures++; $display("FAIL single_len got=%0h exp=100", wst_len[0]); end
        if (runs.size() !== 1 || runs[0] !== 32)
            begin failures++; $display("FAIL single_run n=%0d got=%0d exp=32", runs.size(), runs[0]); end
        if (first_cyc[0] - wst_cyc[0] !== 1)
            begin failures++; $display("FAIL single_latency got=%0d exp=1", first_cyc[0] - wst_cyc[0]); end
        if (got.size() !== 32 || b !== -1) begin failures++; $display("FAIL single_order n=%0d bad_idx=%0d exp=-1", got.size(), b); end
        if (done_idx.size() !== 1 || done_idx[0] !== 32)
            begin failures++; $display("FAIL single_done n=%0d got=%0d exp=32", done_idx.size(), done_idx[0]); end
        if (fifo_cnt !== 0) begin failures++; $display("FAIL single_fifo_cnt got=%0d exp=0", fifo_cnt); end
    endtask

    task automatic test_ring_wrap();
        int acc, b, bad_addr, bad_run, bad_done;
        bit ok;
        logic [31:0] ea [5] = '{32'h1000_0000, 32'h1000_0100, 32'h1000_0200, 32'h1000_0300, 32'h1000_0000};
        clear_mon();
        enable_cfg();
        push_n(160, 400, acc);
        wait_beats(192, 600, ok);
        bad_addr = 0; bad_run = 0; bad_done = 0;
        for (int i = 0; i < 5; i++) begin
            if (wst_addr[i] !== ea[i]) bad_addr++;
            if (runs[i] !== 32) bad_run++;
            if (done_idx[i] !== 64 + 32 * i) bad_done++;
        end
        b = first_bad();
        checks += 5;
        if (!ok || wst_addr.size() !== 5) begin failures++; $display("FAIL wrap_count got=%0d exp=5", wst_addr.size()); end
        if (bad_addr !== 0) begin failures++; $display("FAIL wrap_addr got=%0d wrong exp=0", bad_addr); end
        if (bad_run !== 0 || runs.size() !== 5) begin failures++; $display("FAIL wrap_runs got=%0d wrong exp=0", bad_run); end
        if (bad_done !== 0) begin failures++; $display("FAIL wrap_done got=%0d wrong exp=0", bad_done); end
        if (got.size() !== 192 || b !== -1) begin failures++; $display("FAIL wrap_order n=%0d bad_idx=%0d exp=-1", got.size(), b); end
    endtask

    task automatic test_wready_hold();
        int acc, n0;
        bit ok;
        clear_mon();
        wready = 0;
        n0 = got.size();
        push_n(64, 100, acc);
        repeat (5) @(negedge clk);
        checks += 3;
        if (wst_addr.size() !== 0) begin failures++; $display("FAIL hold_no_wstart got=%0d exp=0", wst_addr.size()); end
        if (fifo_cnt !== 64) begin failures++; $display("FAIL hold_fifo_cnt got=%0d exp=64", fifo_cnt); end
        if (busy !== 0) begin failures++; $display("FAIL hold_busy got=%b exp=0", busy); end
        @(posedge clk); #1 wready = 1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (wstart !== 1) begin failures++; $display("FAIL hold_wstart_next got=%b exp=1", wstart); end
        wready = 0;
        wait_beats(n0 + 32, 200, ok);
        checks += 3;
        if (!ok) begin failures++; $display("FAIL hold_timeout got=%0d exp=%0d", got.size(), n0 + 32); end
        if (fifo_cnt !== 32) begin failures++; $display("FAIL hold_fifo_after got=%0d exp=32", fifo_cnt); end
        if (wst_addr.size() !== 1 || wst_addr[0] !== 32'h1000_0100)
            begin failures++; $display("FAIL hold_addr n=%0d got=%0h exp=10000100", wst_addr.size(), wst_addr[0]); end
    endtask

    task automatic test_back_to_back();
        int acc, n0, b, bad_gap;
        bit ok;
        clear_mon();
        n0 = got.size();
        push_n(64, 100, acc);
        @(posedge clk); #1 wready = 1;
        wait_beats(n0 + 96, 400, ok);
        bad_gap = 0;
        for (int i = 0; i < 3; i++) begin
            if (first_cyc[i] - wst_cyc[i] !== 1) bad_gap++;
            if (i > 0 && wst_cyc[i] - last_cyc[i-1] !== 2) bad_gap++;
        end
        b = first_bad();
        checks += 5;
        if (!ok || wst_addr.size() !== 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", wst_addr.size()); end
        if (wst_addr[0] !== 32'h1000_0200 || wst_addr[1] !== 32'h1000_0300 || wst_addr[2] !== 32'h1000_0000)
            begin failures++; $display("FAIL b2b_addr got=%0h,%0h,%0h exp=10000200,10000300,10000000", wst_addr[0], wst_addr[1], wst_addr[2]); end
        if (bad_gap !== 0) begin failures++; $display("FAIL b2b_gap got=%0d wrong exp=0", bad_gap); end
        if (b !== -1) begin failures++; $display("FAIL b2b_order bad_idx=%0d exp=-1", b); end
        if (fifo_cnt !== 0) begin failures++; $display("FAIL b2b_fifo_cnt got=%0d exp=0", fifo_cnt); end
    endtask

    task automatic test_backpressure();
        int acc, n0, b;
        bit ok;
        clear_mon();
        wready = 0;
        n0 = got.size();
        push_n(600, 520, acc);
        checks += 3;
        if (acc !== 512) begin failures++; $display("FAIL bp_accepted got=%0d exp=512", acc); end
        if (fifo_cnt !== 512) begin failures++; $display("FAIL bp_fifo_cnt got=%0d exp=512", fifo_cnt); end
        if (s_rdy !== 0) begin failures++; $display("FAIL bp_s_rdy got=%b exp=0", s_rdy); end
        @(posedge clk); #1 wready = 1;
        wait_beats(n0 + 512, 2000, ok);
        b = first_bad();
        checks += 4;
        if (!ok || got.size() !== n0 + 512) begin failures++; $display("FAIL bp_drain got=%0d exp=%0d", got.size(), n0 + 512); end
        if (b !== -1) begin failures++; $display("FAIL bp_order bad_idx=%0d exp=-1", b); end
        if (wst_addr.size() !== 16) begin failures++; $display("FAIL bp_bursts got=%0d exp=16", wst_addr.size()); end
        if (fifo_cnt !== 0 || s_rdy !== 1) begin failures++; $display("FAIL bp_empty cnt=%0d rdy=%b exp=0,1", fifo_cnt, s_rdy); end
    endtask

    task automatic test_cfg_drop();
        int acc, n0, k, b;
        bit ok;
        clear_mon();
        enable_cfg();
        wready = 1;
        n0 = got.size();
        push_n(32, 100, acc);
        wait_beats(n0 + 32, 200, ok);
        wready = 0;
        push_n(64, 100, acc);
        clear_mon();
        n0 = got.size();
        wready = 1;
        k = 0;
        for (int c = 0; c < 100 && k < 10; c++) begin
            @(negedge clk);
            if (wdata_vld) k++;
        end
        cfg_en = 0;
        wait_beats(n0 + 32, 200, ok);
        repeat (20) @(negedge clk);
        b = first_bad();
        checks += 5;
        if (!ok || runs.size() !== 1 || runs[0] !== 32) begin failures++; $display("FAIL drop_run n=%0d got=%0d exp=32", runs.size(), runs[0]); end
        if (wst_addr.size() !== 1 || wst_addr[0] !== 32'h1000_0100)
            begin failures++; $display("FAIL drop_wstarts n=%0d addr=%0h exp=1,10000100", wst_addr.size(), wst_addr[0]); end
        if (fifo_cnt !== 32) begin failures++; $display("FAIL drop_retained got=%0d exp=32", fifo_cnt); end
        if (busy !== 0) begin failures++; $display("FAIL drop_busy got=%b exp=0", busy); end
        if (b !== -1) begin failures++; $display("FAIL drop_order bad_idx=%0d exp=-1", b); end
        @(posedge clk); #1 cfg_en = 1;
        wait_beats(n0 + 64, 200, ok);
        checks++;
        if (!ok || wst_addr.size() !== 2 || wst_addr[1] !== 32'h1000_0000)
            begin failures++; $display("FAIL drop_restart n=%0d addr=%0h exp=2,10000000", wst_addr.size(), wst_addr[1]); end
    endtask

    task automatic test_reset_mid_burst();
        int acc, k, vld_seen;
        clear_mon();
        wready = 0;
        push_n(64, 100, acc);
        wready = 1;
        k = 0;
        for (int c = 0; c < 100 && k < 5; c++) begin
            @(negedge clk);
            if (wdata_vld) k++;
        end
        rstn = 0;
        @(negedge clk);
        checks += 5;
        if (k !== 5) begin failures++; $display("FAIL rmid_reach got=%0d exp=5", k); end
        if (wdata_vld !== 0) begin failures++; $display("FAIL rmid_vld got=%b exp=0", wdata_vld); end
        if (fifo_cnt !== 0) begin failures++; $display("FAIL rmid_fifo_cnt got=%0d exp=0", fifo_cnt); end
        if (s_rdy !== 1) begin failures++; $display("FAIL rmid_s_rdy got=%b exp=1", s_rdy); end
        if (busy !== 0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        cfg_en = 0;
        @(posedge clk); #1 rstn = 1;
        vld_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (wdata_vld || wstart) vld_seen++;
        end
        checks++;
        if (vld_seen !== 0) begin failures++; $display("FAIL rmid_quiet got=%0d exp=0", vld_seen); end
        got.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_ring_wrap();
        test_wready_hold();
        test_back_to_back();
        test_backpressure();
        test_cfg_drop();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dma_wr_ctrl.md
DMA_WR_CTRL -- requirements
Module: dma_wr_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width of the write command.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, stream and write-data width (8 bytes per beat).
REQ-003 SHALL have parameter LEN_WIDTH, default 16, byte-length field width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 512, internal buffer depth in beats (power of 2).
REQ-005 SHALL have a single clock; reset is synchronous and active-low. Clock and reset are named clk and rstn.
REQ-006 SHALL have ports:
- clk  in  1  clock (250 MHz domain).
- rstn  in  1  synchronous active-low reset.
- cfg_en  in  1  enable; configuration is sampled on its rising edge.
- cfg_base_addr  in  ADDR_WIDTH  ring buffer base byte address, 8-byte aligned.
- cfg_ring_size  in  ADDR_WIDTH  ring size in bytes; a multiple of cfg_burst_len.
- cfg_burst_len  in  LEN_WIDTH  burst size in bytes; a nonzero multiple of 8.
- s_vld  in  1  input stream beat valid.
- s_data  in  DATA_WIDTH  input stream beat.
- s_rdy  out  1  input ready (buffer not full).
- wready  in  1  datamover can accept a write command.
- wstart  out  1  write command strobe, one cycle.
- waddr  out  ADDR_WIDTH  command byte address.
- wdata_len  out  LEN_WIDTH  command byte length.
- wdata_vld  out  1  write data valid; there is no backpressure on write data.
- wdata  out  DATA_WIDTH  write data.
- busy  out  1  burst in progress.
- burst_done  out  1  one-cycle pulse on the last data beat of a burst.
- fifo_cnt  out  log2(FIFO_DEPTH)+1  buffered beat count.

Function
REQ-007 SHALL accept an input beat when s_vld and s_rdy are both 1; s_rdy = (fifo_cnt < FIFO_DEPTH).
REQ-008 SHALL latch cfg_base_addr, cfg_ring_size and cfg_burst_len on the cfg_en 0->1 edge, and clear the ring offset to 0 at the same edge; cfg changes while enabled SHALL be ignored.
REQ-009 SHALL use burst_beats = cfg_burst_len/8 computed from the latched value.
REQ-010 SHALL implement FSM states IDLE, CMD and DATA; reset state is IDLE.
REQ-011 IDLE->CMD SHALL occur when cfg_en=1 and wready=1 and fifo_cnt >= burst_beats; otherwise the FSM remains in IDLE.
REQ-012 In CMD (one cycle), the block SHALL drive wstart=1, waddr=base+offset and wdata_len=latched burst_len, then go to DATA.
REQ-013 In DATA, the block SHALL drive wdata_vld=1 on exactly burst_beats consecutive cycles, starting the cycle after wstart, with data in FIFO order.
REQ-014 On the last DATA beat, the block SHALL pulse burst_done; offset SHALL become (offset+burst_len == ring_size) ? 0 : offset+burst_len; the FSM SHALL return to IDLE.
REQ-015 The minimum gap SHALL be one IDLE cycle between the last beat and the next wstart.
REQ-016 busy SHALL be 1 in the CMD and DATA states.
REQ-017 If cfg_en falls mid-burst, the block SHALL complete the current burst and then remain in IDLE; buffered data SHALL be retained.
REQ-018 On simultaneous FIFO push and pop, fifo_cnt SHALL stay unchanged; a push at full SHALL be impossible because s_rdy=0.
REQ-019 waddr and wdata_len SHALL hold their values outside CMD; wdata SHALL be don't-care when wdata_vld=0.
REQ-020 Address arithmetic SHALL be modulo 2^ADDR_WIDTH; no carry is retained.

Reset
REQ-021 While rstn=0 at a clk edge, the block SHALL return to IDLE; the FIFO SHALL be flushed; fifo_cnt, offset, wstart, wdata_vld, burst_done and busy SHALL be 0; waddr, wdata_len and wdata SHALL be 0; s_rdy SHALL be 1 from the first cycle after reset.
REQ-022 Reset asserted mid-burst SHALL abort the burst immediately, with no further wdata_vld.

Verification
REQ-023 Base 0x1000_0000, ring 0x400, burst 0x100, wready=1; push 32 beats -> wstart with waddr 0x1000_0000/len 0x100, 32 wdata_vld beats, data order preserved, burst_done on beat 32.
REQ-024 Ring wrap: with the same cfg, push 160 beats -> 5 bursts at waddr 0x1000_0000, 0x100, 0x200, 0x300, then 0x1000_0000.
REQ-025 wready=0 with 64 beats buffered -> no wstart; wready rises -> wstart on the next cycle; fifo_cnt decreases to 32 after the burst.
REQ-026 Backpressure: push continuously with wready=0 -> s_rdy falls when fifo_cnt=512; no beats are lost after wready releases.
REQ-027 Drop cfg_en on DATA beat 10 -> remaining 22 beats are sent, then no further wstart; re-enable -> offset restarts at base.
REQ-028 Assert rstn=0 on DATA beat 5 -> wdata_vld=0 the next cycle, fifo_cnt=0, s_rdy=1.
